// File: rtl/uart_irq_pkg.sv
// UART interrupt controller shared package.
// Register offsets, IMR mode encoding, IDR layout, source limit.
package uart_irq_pkg;

  localparam int NUM_SRC_MAX = 32;

  localparam int OFF_IER = 'h00;
  localparam int OFF_ISR = 'h04;
  localparam int OFF_IMR = 'h08;
  localparam int OFF_IPR = 'h0C;
  localparam int OFF_IDR = 'h10;

  localparam logic IMR_LEVEL = 1'b0;
  localparam logic IMR_EDGE  = 1'b1;

  localparam int IDR_IDX_W = 6;
  localparam int IDR_ANY   = 31;

endpackage

// File: rtl/uart_irq_prio.sv
// Lowest-index priority encoder producing the IDR word.
// Ports: ipr_i pending&enabled vector; idr_o {any,0..,index}.
module uart_irq_prio
  import uart_irq_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] ipr_i,
  output logic [31:0]  idr_o
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idr_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ipr_i[i]) begin
        idr_o[IDR_IDX_W-1:0] = IDR_IDX_W'(i);
      end
    end
    idr_o[IDR_ANY] = |ipr_i;
  end

endmodule

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller with an APB register file.
// Ports: APB slave (pclk/preset/psel/penable/pwrite/paddr/pwdata/
// pstrb/prdata/pready/pslverr), src_i sources, irq_o, irq_any_o.
module uart_irq_ctrl
  import uart_irq_pkg::*;
#(
  parameter int NUM_SRC = 5,
  parameter int ADDR_W  = 8
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic [31:0]        pwdata,
  input  logic [3:0]         pstrb,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [NUM_SRC-1:0] irq_o,
  output logic               irq_any_o
);

  logic [NUM_SRC-1:0] ier_q, ier_d;
  logic [NUM_SRC-1:0] isr_q, isr_d;
  logic [NUM_SRC-1:0] imr_q, imr_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] irq_q;
  logic               any_q;

  logic [NUM_SRC-1:0] ipr;
  logic [NUM_SRC-1:0] set;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] wm;
  logic [NUM_SRC-1:0] wd;
  logic [31:0]        wmask;
  logic [31:0]        idr;

  logic acc, err, wr_ok, rd_en, mapped, misal;
  logic sel_ier, sel_isr, sel_imr, sel_ipr, sel_idr;

  assign sel_ier = (paddr == ADDR_W'(OFF_IER));
  assign sel_isr = (paddr == ADDR_W'(OFF_ISR));
  assign sel_imr = (paddr == ADDR_W'(OFF_IMR));
  assign sel_ipr = (paddr == ADDR_W'(OFF_IPR));
  assign sel_idr = (paddr == ADDR_W'(OFF_IDR));

  assign mapped = sel_ier | sel_isr | sel_imr
                | sel_ipr | sel_idr;
  assign misal  = |paddr[1:0];
  assign acc    = psel & penable;

  assign err = acc & (~mapped | misal
             | (pwrite & (sel_ipr | sel_idr)));

  assign wr_ok = acc & pwrite & ~err & ~preset;
  assign rd_en = psel & ~pwrite & ~preset;

  assign pready  = 1'b1;
  assign pslverr = err & ~preset;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{pstrb[b]}};
    end
  end

  assign wm = wmask[NUM_SRC-1:0];
  assign wd = pwdata[NUM_SRC-1:0] & wm;

  // Bits above NUM_SRC of the write bus are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{pwdata, wmask};

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (imr_q[i] == IMR_EDGE) begin
        set[i] = src_i[i] & ~src_q[i];
      end else begin
        set[i] = src_i[i];
      end
    end
  end

  assign clr = (wr_ok & sel_isr) ? wd : '0;

  // Set is OR'd in last so it wins over a same-cycle W1C.
  assign isr_d = (isr_q & ~clr) | set;

  assign ier_d = (wr_ok & sel_ier)
               ? ((ier_q & ~wm) | wd) : ier_q;
  assign imr_d = (wr_ok & sel_imr)
               ? ((imr_q & ~wm) | wd) : imr_q;

  assign ipr = isr_q & ier_q;

  uart_irq_prio #(
    .N (NUM_SRC)
  ) u_prio (
    .ipr_i (ipr),
    .idr_o (idr)
  );

  always_comb begin
    prdata = '0;
    if (rd_en && !misal) begin
      unique case (1'b1)
        sel_ier: prdata = 32'(ier_q);
        sel_isr: prdata = 32'(isr_q);
        sel_imr: prdata = 32'(imr_q);
        sel_ipr: prdata = 32'(ipr);
        sel_idr: prdata = idr;
        default: prdata = '0;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      ier_q <= '0;
      isr_q <= '0;
      imr_q <= '0;
      src_q <= '0;
      irq_q <= '0;
      any_q <= 1'b0;
    end else begin
      ier_q <= ier_d;
      isr_q <= isr_d;
      imr_q <= imr_d;
      src_q <= src_i;
      irq_q <= ipr;
      any_q <= |ipr;
    end
  end

  assign irq_o     = irq_q;
  assign irq_any_o = any_q;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Directed self-checking bench for uart_irq_ctrl.
// APB accesses via tasks; all results go through chk.
module tb_uart_irq_ctrl;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [4:0]  src;
  logic [4:0]  irq;
  logic        irq_any;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] rd;
  logic        e;

  always #5 pclk = ~pclk;

  uart_irq_ctrl #(
    .NUM_SRC (5),
    .ADDR_W  (8)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .src_i     (src),
    .irq_o     (irq),
    .irq_any_o (irq_any)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input  logic [7:0]  a,
                        input  logic [31:0] d,
                        input  logic [3:0]  s,
                        output logic        er);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = a; pwdata = d; pstrb = s;
    tick();
    penable = 1'b1;
    #1;
    er = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input  logic [7:0]  a,
                        output logic [31:0] d,
                        output logic        er);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = a;
    tick();
    penable = 1'b1;
    #1;
    d  = prdata;
    er = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    preset = 1'b1; src = '0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 8'h00; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;

    // Access held in progress across reset.
    tick();
    pwrite = 1'b0; paddr = 8'h14;
    #1;
    chk("rst_prdata", prdata, 0);
    chk("rst_slverr", 32'(pslverr), 0);
    chk("rst_pready", 32'(pready), 1);
    tick();
    psel = 1'b0; penable = 1'b0;
    preset = 1'b0;
    tick();
    chk("rst_irq", 32'(irq), 0);
    chk("rst_any", 32'(irq_any), 0);
    apb_rd(8'h00, rd, e); chk("rst_ier", rd, 0);
    apb_rd(8'h04, rd, e); chk("rst_isr", rd, 0);
    apb_rd(8'h08, rd, e); chk("rst_imr", rd, 0);
    apb_rd(8'h10, rd, e); chk("rst_idr", rd, 0);

    // Level source 1: ISR at +1 edge, irq at +2.
    apb_wr(8'h00, 32'h02, 4'hF, e);
    chk("a_wr_err", 32'(e), 0);
    src[1] = 1'b1;
    tick();
    chk("a_irq_e1", 32'(irq), 0);
    tick();
    chk("a_irq_e2", 32'(irq), 32'h02);
    chk("a_any_e2", 32'(irq_any), 1);
    apb_rd(8'h04, rd, e); chk("a_isr", rd, 32'h02);
    src[1] = 1'b0;
    apb_wr(8'h04, 32'h02, 4'hF, e);
    tick();
    chk("a_irq_clr", 32'(irq), 0);
    apb_rd(8'h04, rd, e); chk("a_isr_clr", rd, 0);

    // Edge source 0, one-cycle pulse, sticky until W1C.
    apb_wr(8'h08, 32'h01, 4'hF, e);
    apb_wr(8'h00, 32'h01, 4'hF, e);
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    tick();
    tick();
    chk("b_irq", 32'(irq), 32'h01);
    apb_rd(8'h04, rd, e); chk("b_isr", rd, 32'h01);
    apb_wr(8'h04, 32'h01, 4'hF, e);
    chk("b_irq_hold", 32'(irq), 32'h01);
    tick();
    chk("b_irq_fall", 32'(irq), 0);
    apb_rd(8'h04, rd, e); chk("b_no_reset", rd, 0);

    // Level source 3 held high: W1C cannot clear it.
    apb_wr(8'h08, 32'h00, 4'hF, e);
    apb_wr(8'h00, 32'h08, 4'hF, e);
    src[3] = 1'b1;
    tick(); tick(); tick();
    chk("c_irq", 32'(irq), 32'h08);
    apb_wr(8'h04, 32'h08, 4'hF, e);
    apb_rd(8'h04, rd, e); chk("c_isr_reset", rd, 32'h08);
    chk("c_irq_stay", 32'(irq), 32'h08);
    src[3] = 1'b0;
    apb_wr(8'h04, 32'h08, 4'hF, e);
    tick();
    chk("c_irq_off", 32'(irq), 0);

    // Edge on source 2 at the same edge as its W1C.
    apb_wr(8'h08, 32'h04, 4'hF, e);
    apb_wr(8'h00, 32'h04, 4'hF, e);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h04; pwdata = 32'h04; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    src[2] = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    src[2] = 1'b0;
    apb_rd(8'h04, rd, e); chk("d_set_wins", rd, 32'h04);
    apb_wr(8'h04, 32'h04, 4'hF, e);
    apb_rd(8'h04, rd, e); chk("d_isr_clr", rd, 0);

    // Priority: sources 4 and 2 pending.
    apb_wr(8'h08, 32'h00, 4'hF, e);
    apb_wr(8'h00, 32'h1F, 4'hF, e);
    src = 5'h14;
    tick();
    src = 5'h00;
    apb_rd(8'h0C, rd, e); chk("e_ipr", rd, 32'h14);
    apb_rd(8'h10, rd, e); chk("e_idr2", rd, 32'h8000_0002);
    apb_wr(8'h04, 32'h04, 4'hF, e);
    apb_rd(8'h10, rd, e); chk("e_idr4", rd, 32'h8000_0004);
    chk("e_irq", 32'(irq), 32'h10);
    chk("e_any", 32'(irq_any), 1);

    // IER off masks irq next edge but keeps ISR.
    apb_wr(8'h00, 32'h00, 4'hF, e);
    chk("e_ier_lag", 32'(irq), 32'h10);
    tick();
    chk("e_ier_mask", 32'(irq), 0);
    chk("e_ier_any", 32'(irq_any), 0);
    apb_rd(8'h04, rd, e); chk("e_isr_kept", rd, 32'h10);
    apb_wr(8'h08, 32'h1F, 4'hF, e);
    apb_rd(8'h04, rd, e); chk("e_imr_kept", rd, 32'h10);

    // Byte strobes and unimplemented bits.
    apb_wr(8'h00, 32'hFFFF_FFFF, 4'h2, e);
    apb_rd(8'h00, rd, e); chk("f_strb_b1", rd, 0);
    apb_wr(8'h00, 32'hFFFF_FFFF, 4'h1, e);
    apb_rd(8'h00, rd, e); chk("f_strb_b0", rd, 32'h1F);

    // Error accesses leave state unchanged.
    apb_wr(8'h0C, 32'hFF, 4'hF, e); chk("g_wr_ipr", 32'(e), 1);
    apb_wr(8'h10, 32'hFF, 4'hF, e); chk("g_wr_idr", 32'(e), 1);
    apb_rd(8'h14, rd, e); chk("g_rd_14", 32'(e), 1);
    apb_wr(8'h02, 32'h00, 4'hF, e); chk("g_misal", 32'(e), 1);
    apb_rd(8'h00, rd, e); chk("g_ier", rd, 32'h1F);
    chk("g_ier_err", 32'(e), 0);
    apb_rd(8'h0C, rd, e); chk("g_ipr", rd, 32'h10);
    chk("g_irq", 32'(irq), 32'h10);

    // Reset while an interrupt is pending.
    preset = 1'b1;
    tick();
    chk("h_irq", 32'(irq), 0);
    chk("h_any", 32'(irq_any), 0);
    preset = 1'b0;
    apb_rd(8'h04, rd, e); chk("h_isr", rd, 0);
    apb_rd(8'h00, rd, e); chk("h_ier", rd, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
